// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, the PC register, instruction memory and decode.
// The fetch unit uses the master modport; its environment uses the slave modport.
interface fetch_unit_if;
  logic [63:0] pc_i;
  logic        pc_we_o;
  logic [63:0] npc_o;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_misalign_o;
  logic        inst_acc_fault_o;

  modport master (
    input  pc_i, redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
    output pc_we_o, npc_o, imem_req_valid_o, imem_req_addr_o,
           inst_valid_o, inst_o, inst_pc_o, inst_misalign_o, inst_acc_fault_o
  );

  modport slave (
    output pc_i, redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i, inst_ready_i,
    input  pc_we_o, npc_o, imem_req_valid_o, imem_req_addr_o,
           inst_valid_o, inst_o, inst_pc_o, inst_misalign_o, inst_acc_fault_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: one memory request per instruction,
// a one-entry buffer towards decode, and redirect handling with response draining.
module fetch_unit (
  input  logic         clk_i,
  input  logic         rst_ni,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;
  logic        acc_fault_q, acc_fault_d;

  logic        redirect;
  logic        pc_aligned;
  logic        req_valid;
  logic        pc_we;
  logic [63:0] npc;
  logic        inst_valid;

  // A redirect only ever wins over the +4 update; in IDLE it is ignored entirely.
  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    misalign_d  = misalign_q;
    acc_fault_d = acc_fault_q;
    req_valid   = 1'b0;
    pc_we       = 1'b0;
    npc         = 64'd0;
    inst_valid  = 1'b0;
    redirect    = bus.redirect_valid_i && (state_q != IDLE);
    pc_aligned  = (bus.pc_i[1:0] == 2'b00);

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req_valid = pc_aligned;
        if (redirect) begin
          state_d = (pc_aligned && bus.imem_req_ready_i) ? DRAIN : REQ;
        end else if (!pc_aligned) begin
          inst_pc_d   = bus.pc_i;
          inst_d      = 32'd0;
          misalign_d  = 1'b1;
          acc_fault_d = 1'b0;
          state_d     = HOLD;
        end else if (bus.imem_req_ready_i) begin
          inst_pc_d   = bus.pc_i;
          misalign_d  = 1'b0;
          acc_fault_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          if (redirect) begin
            state_d = REQ;
          end else begin
            inst_d      = bus.imem_rsp_err_i ? 32'd0 : bus.imem_rsp_data_i;
            acc_fault_d = bus.imem_rsp_err_i;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        inst_valid = !redirect;
        if (redirect) begin
          state_d = REQ;
        end else if (bus.inst_ready_i) begin
          if (misalign_q || acc_fault_q) begin
            state_d = FAULT;
          end else begin
            pc_we   = 1'b1;
            npc     = bus.pc_i + 64'd4;
            state_d = REQ;
          end
        end
      end
      FAULT: begin
        if (redirect) state_d = REQ;
      end
      DRAIN: begin
        if (bus.imem_rsp_valid_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_we = 1'b1;
      npc   = bus.redirect_pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      inst_q      <= 32'd0;
      inst_pc_q   <= 64'd0;
      misalign_q  <= 1'b0;
      acc_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      misalign_q  <= misalign_d;
      acc_fault_q <= acc_fault_d;
    end
  end

  assign bus.pc_we_o          = pc_we;
  assign bus.npc_o            = npc;
  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = (state_q == IDLE) ? 64'd0 : bus.pc_i;
  assign bus.inst_valid_o     = inst_valid;
  assign bus.inst_o           = inst_q;
  assign bus.inst_pc_o        = inst_pc_q;
  assign bus.inst_misalign_o  = misalign_q;
  assign bus.inst_acc_fault_o = acc_fault_q;

  // Responses are only legal while one is outstanding; stray ones are dropped.
  rsp_only_when_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.imem_rsp_valid_i |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, a mid-transaction reset sequence, and a randomized run
// checked against an instruction-stream model of fetch.
module tb_fetch_unit;

  localparam logic [63:0] P   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] R   = 64'h0000_0000_8000_1000;
  localparam logic [63:0] T   = 64'h0000_0000_8000_2000;
  localparam logic [63:0] M   = 64'h0000_0000_8000_0002;
  localparam logic [63:0] S   = 64'h0000_0000_8000_0010;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I2  = 32'h00A0_0093;
  localparam logic [31:0] I3  = 32'h0000_0513;

  typedef struct {
    string       name;
    logic        rr, rv;
    logic [31:0] rd;
    logic        re, ir, rdv;
    logic [63:0] rdp;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_mis, e_acc, e_we;
    logic [63:0] e_npc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc_reg;
  logic [63:0] pc_reset = P;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[$];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) pc_reg <= pc_reset;
    else if (bus.pc_we_o) pc_reg <= bus.npc_o;
  end
  assign bus.pc_i = pc_reg;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  function automatic logic mem_err(input logic [63:0] a);
    return a[7:2] == 6'h2A;
  endfunction

  function automatic vec_t row(input string n, input logic rr, rv, input logic [31:0] rd,
                               input logic re, ir, rdv, input logic [63:0] rdp,
                               input logic eq, input logic [63:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [63:0] ep,
                               input logic em, eac, ew, input logic [63:0] en);
    vec_t v;
    v.name = n; v.rr = rr; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir; v.rdv = rdv; v.rdp = rdp;
    v.e_req = eq; v.e_addr = ea; v.e_val = ev; v.e_inst = ei; v.e_pc = ep;
    v.e_mis = em; v.e_acc = eac; v.e_we = ew; v.e_npc = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'd0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.inst_ready_i     = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = 64'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.imem_req_ready_i = v.rr;
    bus.imem_rsp_valid_i = v.rv;
    bus.imem_rsp_data_i  = v.rd;
    bus.imem_rsp_err_i   = v.re;
    bus.inst_ready_i     = v.ir;
    bus.redirect_valid_i = v.rdv;
    bus.redirect_pc_i    = v.rdp;
  endtask

  task automatic checkOutput(input vec_t v);
    @(negedge clk);
    chk1({v.name, ".req_valid"}, bus.imem_req_valid_o, v.e_req);
    if (v.e_req) chk({v.name, ".req_addr"}, bus.imem_req_addr_o, v.e_addr);
    chk1({v.name, ".inst_valid"}, bus.inst_valid_o, v.e_val);
    chk({v.name, ".inst"}, {32'd0, bus.inst_o}, {32'd0, v.e_inst});
    chk({v.name, ".inst_pc"}, bus.inst_pc_o, v.e_pc);
    chk1({v.name, ".misalign"}, bus.inst_misalign_o, v.e_mis);
    chk1({v.name, ".acc_fault"}, bus.inst_acc_fault_o, v.e_acc);
    chk1({v.name, ".pc_we"}, bus.pc_we_o, v.e_we);
    chk({v.name, ".npc"}, bus.npc_o, v.e_npc);
    step();
  endtask

  initial begin
    logic        rsp_v, redir, fault_wait, busy_prev, mis_e, acc_e;
    logic [63:0] exp_pc, tgt, mem_addr;
    bit          mem_busy;
    int          mem_cnt, hs;

    //    name           rr rv rd            re ir rdv rdp   eq ea    ev inst ipc    mis acc we npc
    tbl.push_back(row("idle",        0, 0, 0,            0, 0, 0, 0,    0, 0,    0, 0,   0,    0, 0, 0, 0));
    tbl.push_back(row("req0",        1, 0, 0,            0, 0, 0, 0,    1, P,    0, 0,   0,    0, 0, 0, 0));
    tbl.push_back(row("wait0",       0, 1, NOP,          0, 0, 0, 0,    0, 0,    0, 0,   P,    0, 0, 0, 0));
    tbl.push_back(row("hold0",       0, 0, 0,            0, 1, 0, 0,    0, 0,    1, NOP, P,    0, 0, 1, P+4));
    tbl.push_back(row("req1",        1, 0, 0,            0, 0, 0, 0,    1, P+4,  0, NOP, P,    0, 0, 0, 0));
    tbl.push_back(row("wait1",       0, 1, NOP,          0, 0, 0, 0,    0, 0,    0, NOP, P+4,  0, 0, 0, 0));
    tbl.push_back(row("hold1",       0, 0, 0,            0, 1, 0, 0,    0, 0,    1, NOP, P+4,  0, 0, 1, P+8));
    tbl.push_back(row("req2",        1, 0, 0,            0, 0, 0, 0,    1, P+8,  0, NOP, P+4,  0, 0, 0, 0));
    tbl.push_back(row("wait2",       0, 1, NOP,          0, 0, 0, 0,    0, 0,    0, NOP, P+8,  0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(row("stall",     1, 0, 0,            0, 0, 0, 0,    0, 0,    1, NOP, P+8,  0, 0, 0, 0));
    tbl.push_back(row("hold2",       0, 0, 0,            0, 1, 0, 0,    0, 0,    1, NOP, P+8,  0, 0, 1, P+12));
    tbl.push_back(row("req3",        1, 0, 0,            0, 0, 0, 0,    1, P+12, 0, NOP, P+8,  0, 0, 0, 0));
    tbl.push_back(row("wait3",       0, 0, 0,            0, 0, 0, 0,    0, 0,    0, NOP, P+12, 0, 0, 0, 0));
    tbl.push_back(row("redir_wait",  0, 0, 0,            0, 0, 1, R,    0, 0,    0, NOP, P+12, 0, 0, 1, R));
    tbl.push_back(row("drain0",      0, 0, 0,            0, 0, 0, 0,    0, 0,    0, NOP, P+12, 0, 0, 0, 0));
    tbl.push_back(row("drain1",      0, 1, 32'hDEADBEEF, 0, 0, 0, 0,    0, 0,    0, NOP, P+12, 0, 0, 0, 0));
    tbl.push_back(row("req_r",       1, 0, 0,            0, 0, 0, 0,    1, R,    0, NOP, P+12, 0, 0, 0, 0));
    tbl.push_back(row("wait_r",      0, 1, I2,           0, 0, 0, 0,    0, 0,    0, NOP, R,    0, 0, 0, 0));
    tbl.push_back(row("redir_hold",  0, 0, 0,            0, 1, 1, T,    0, 0,    0, I2,  R,    0, 0, 1, T));
    tbl.push_back(row("req_t_stall", 0, 0, 0,            0, 0, 0, 0,    1, T,    0, I2,  R,    0, 0, 0, 0));
    tbl.push_back(row("req_t",       1, 0, 0,            0, 0, 0, 0,    1, T,    0, I2,  R,    0, 0, 0, 0));
    tbl.push_back(row("wait_err",    0, 1, 32'h12345678, 1, 0, 0, 0,    0, 0,    0, I2,  T,    0, 0, 0, 0));
    tbl.push_back(row("hold_err",    0, 0, 0,            0, 1, 0, 0,    0, 0,    1, 0,   T,    0, 1, 0, 0));
    tbl.push_back(row("fault0",      1, 0, 0,            0, 1, 0, 0,    0, 0,    0, 0,   T,    0, 1, 0, 0));
    tbl.push_back(row("fault1",      1, 0, 0,            0, 1, 0, 0,    0, 0,    0, 0,   T,    0, 1, 0, 0));
    tbl.push_back(row("redir_fault", 0, 0, 0,            0, 0, 1, M,    0, 0,    0, 0,   T,    0, 1, 1, M));
    tbl.push_back(row("req_mis",     1, 0, 0,            0, 0, 0, 0,    0, 0,    0, 0,   T,    0, 1, 0, 0));
    tbl.push_back(row("hold_mis_st", 0, 0, 0,            0, 0, 0, 0,    0, 0,    1, 0,   M,    1, 0, 0, 0));
    tbl.push_back(row("hold_mis",    0, 0, 0,            0, 1, 0, 0,    0, 0,    1, 0,   M,    1, 0, 0, 0));
    tbl.push_back(row("fault_mis",   1, 0, 0,            0, 1, 0, 0,    0, 0,    0, 0,   M,    1, 0, 0, 0));
    tbl.push_back(row("redir_res",   0, 0, 0,            0, 0, 1, S,    0, 0,    0, 0,   M,    1, 0, 1, S));
    tbl.push_back(row("req_s",       1, 0, 0,            0, 0, 0, 0,    1, S,    0, 0,   M,    1, 0, 0, 0));
    tbl.push_back(row("wait_s",      0, 1, I3,           0, 0, 0, 0,    0, 0,    0, 0,   S,    0, 0, 0, 0));
    tbl.push_back(row("hold_s",      0, 0, 0,            0, 1, 0, 0,    0, 0,    1, I3,  S,    0, 0, 1, S+4));
    tbl.push_back(row("req_s4",      0, 0, 0,            0, 0, 0, 0,    1, S+4,  0, I3,  S,    0, 0, 0, 0));

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Reset while a response is outstanding: back to IDLE with a cleared buffer.
    drive_idle();
    bus.imem_req_ready_i = 1'b1;
    @(negedge clk);
    chk1("mid_rst.req_valid", bus.imem_req_valid_o, 1'b1);
    step();
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h1234;
    @(negedge clk);
    chk1("idle_redir.pc_we", bus.pc_we_o, 1'b0);
    chk1("idle_redir.req_valid", bus.imem_req_valid_o, 1'b0);
    chk("idle_redir.inst_pc", bus.inst_pc_o, 64'd0);
    chk("idle_redir.inst", {32'd0, bus.inst_o}, 64'd0);
    chk("idle_redir.npc", bus.npc_o, 64'd0);
    step();
    drive_idle();
    @(negedge clk);
    chk1("after_rst.req_valid", bus.imem_req_valid_o, 1'b1);
    chk("after_rst.req_addr", bus.imem_req_addr_o, P);
    step();

    // Randomized run starting just below the 2^64 wrap point.
    pc_reset = 64'hFFFF_FFFF_FFFF_FFF0;
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n      = 1'b1;
    exp_pc     = pc_reset;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    mem_addr   = 64'd0;
    fault_wait = 1'b0;
    hs         = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rsp_v = mem_busy && (mem_cnt == 0);
      bus.imem_rsp_valid_i = rsp_v;
      bus.imem_rsp_data_i  = rsp_v ? mem_word(mem_addr) : $urandom();
      bus.imem_rsp_err_i   = rsp_v ? mem_err(mem_addr) : 1'b0;
      bus.imem_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.inst_ready_i     = ($urandom_range(0, 9) < 7);
      redir = (cyc >= 1) && (fault_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0));
      tgt = {32'd0, $urandom()} & ~64'h3;
      if ($urandom_range(0, 7) == 0) tgt[1] = 1'b1;
      if ($urandom_range(0, 15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
      bus.redirect_valid_i = redir;
      bus.redirect_pc_i    = tgt;
      @(negedge clk);

      if (fault_wait) begin
        chk1("rnd.fault_no_req", bus.imem_req_valid_o, 1'b0);
        chk1("rnd.fault_no_valid", bus.inst_valid_o, 1'b0);
      end
      if (redir) begin
        chk1("rnd.redir_we", bus.pc_we_o, 1'b1);
        chk("rnd.redir_npc", bus.npc_o, tgt);
        chk1("rnd.redir_valid", bus.inst_valid_o, 1'b0);
      end else if (bus.inst_valid_o && bus.inst_ready_i) begin
        hs++;
        mis_e = (exp_pc[1:0] != 2'b00);
        acc_e = !mis_e && mem_err(exp_pc);
        chk("rnd.inst_pc", bus.inst_pc_o, exp_pc);
        chk1("rnd.misalign", bus.inst_misalign_o, mis_e);
        chk1("rnd.acc_fault", bus.inst_acc_fault_o, acc_e);
        chk("rnd.inst", {32'd0, bus.inst_o}, (mis_e || acc_e) ? 64'd0 : {32'd0, mem_word(exp_pc)});
        if (mis_e || acc_e) begin
          chk1("rnd.fault_no_we", bus.pc_we_o, 1'b0);
          fault_wait = 1'b1;
        end else begin
          chk1("rnd.seq_we", bus.pc_we_o, 1'b1);
          chk("rnd.seq_npc", bus.npc_o, exp_pc + 64'd4);
        end
        exp_pc = exp_pc + 64'd4;
      end else begin
        chk1("rnd.no_we", bus.pc_we_o, 1'b0);
      end

      busy_prev = mem_busy;
      if (rsp_v) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        chk1("rnd.single_outstanding", busy_prev, 1'b0);
        chk("rnd.req_addr", bus.imem_req_addr_o, exp_pc);
        mem_busy = 1'b1;
        mem_addr = bus.imem_req_addr_o;
        mem_cnt  = $urandom_range(0, 3);
      end
      if (redir) begin
        exp_pc     = tgt;
        fault_wait = 1'b0;
      end
      step();
    end
    chk1("rnd.progress", (hs >= 60), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
